// File: rtl/exec_iter_muldiv_pkg.sv
// exec_iter_muldiv_pkg: shared encodings for the iterative multiply/divide unit
package exec_iter_muldiv_pkg;
    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;
    // every quotient bit of a divide by zero is set
    localparam logic DIVZERO_Q_BIT = 1'b1;
endpackage

// File: rtl/exec_divstep.sv
// exec_divstep: one combinational restoring-division step
module exec_divstep #(
    parameter int W_OPR = 32
) (
    input  logic [W_OPR-1:0] i_rem,
    input  logic             i_bit,
    input  logic [W_OPR-1:0] i_div,
    output logic [W_OPR-1:0] o_rem,
    output logic             o_q
);
    logic [W_OPR:0] w_sh;
    assign w_sh  = {i_rem, i_bit};
    assign o_q   = w_sh >= {1'b0, i_div};
    // the partial remainder stays below the divisor, so a W-bit subtract is exact
    assign o_rem = o_q ? w_sh[W_OPR-1:0] - i_div : w_sh[W_OPR-1:0];
endmodule

// File: rtl/exec_iter_muldiv.sv
// exec_iter_muldiv: iterative shift-add multiplier / restoring divider, one bit per clock
module exec_iter_muldiv
    import exec_iter_muldiv_pkg::*;
#(
    parameter int W_OPR     = 32,
    parameter int W_RD      = 5,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic [1:0]       op_i,
    input  logic             sign_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic             flush_i,
    input  logic             stall_i,
    output logic             stall_o,
    output logic             v_o,
    output logic [W_OPR-1:0] result_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic             divzero_o
);
    localparam int W_CNT = $clog2(W_OPR);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(W_OPR - 1);

    state_e               r_state, w_nxt;
    op_e                  r_op;
    logic [W_CNT-1:0]     r_cnt;
    logic [2*W_OPR-1:0]   r_prod;
    logic [W_OPR-1:0]     r_b, r_res;
    logic [W_RD-1:0]      r_wb;
    logic                 r_neg, r_dz;

    logic                 w_acc, w_div, w_dz, w_sgn, w_s0, w_s1, w_rdiv, w_qbit;
    logic [W_OPR-1:0]     w_m0, w_m1, w_rem, w_q, w_r, w_fix_res;
    logic [W_OPR:0]       w_sum;
    logic [2*W_OPR-1:0]   w_pfix;

    assign stall_o   = (r_state == ST_BUSY) | (r_state == ST_FIX) | ((r_state == ST_DONE) & stall_i);
    assign w_acc     = v_i & ~stall_o & ~flush_i;
    assign w_div     = op_i[1];
    assign w_dz      = w_div & (opr1_i == '0);
    assign w_sgn     = SIGNED_EN & sign_i;
    assign w_s0      = w_sgn & opr0_i[W_OPR-1];
    assign w_s1      = w_sgn & opr1_i[W_OPR-1];
    assign w_m0      = w_s0 ? -opr0_i : opr0_i;
    assign w_m1      = w_s1 ? -opr1_i : opr1_i;
    assign w_rdiv    = (r_op == OP_DIV) | (r_op == OP_REM);
    // multiply: r_prod holds {partial sum, remaining multiplier}; divide: {remainder, dividend/quotient}
    assign w_sum     = {1'b0, r_prod[2*W_OPR-1:W_OPR]} + (r_prod[0] ? {1'b0, r_b} : '0);
    assign w_pfix    = r_neg ? -r_prod : r_prod;
    assign w_q       = r_neg ? -r_prod[W_OPR-1:0] : r_prod[W_OPR-1:0];
    assign w_r       = r_neg ? -r_prod[2*W_OPR-1:W_OPR] : r_prod[2*W_OPR-1:W_OPR];
    assign w_fix_res = (r_op == OP_MUL)  ? w_pfix[W_OPR-1:0] :
                       (r_op == OP_MULH) ? w_pfix[2*W_OPR-1:W_OPR] :
                       (r_op == OP_DIV)  ? w_q : w_r;

    assign v_o       = r_state == ST_DONE;
    assign result_o  = r_res;
    assign wb_r_o    = r_wb;
    assign divzero_o = r_dz;

    exec_divstep #(.W_OPR(W_OPR)) u_divstep (
        .i_rem (r_prod[2*W_OPR-1:W_OPR]),
        .i_bit (r_prod[W_OPR-1]),
        .i_div (r_b),
        .o_rem (w_rem),
        .o_q   (w_qbit)
    );

    always_comb begin
        w_nxt = r_state;
        w_nxt = flush_i                                           ? ST_IDLE :
                w_acc                                             ? (w_dz ? ST_DONE : ST_BUSY) :
                ((r_state == ST_BUSY) & (r_cnt == CNT_LAST))      ? ST_FIX :
                (r_state == ST_FIX)                               ? ST_DONE :
                ((r_state == ST_DONE) & ~stall_i)                 ? ST_IDLE : r_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op   <= OP_MUL;
            r_cnt  <= '0;
            r_prod <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_wb   <= '0;
            r_neg  <= 1'b0;
            r_dz   <= 1'b0;
        end else if (flush_i) begin
            r_dz   <= 1'b0;
        end else if (w_acc) begin
            r_op   <= op_e'(op_i);
            r_wb   <= wb_r_i;
            r_cnt  <= '0;
            r_b    <= w_div ? w_m1 : w_m0;
            r_prod <= {{W_OPR{1'b0}}, w_div ? w_m0 : w_m1};
            r_neg  <= (op_i == OP_REM) ? w_s0 : w_s0 ^ w_s1;
            r_dz   <= w_dz;
            if (w_dz) r_res <= (op_i == OP_DIV) ? {W_OPR{DIVZERO_Q_BIT}} : opr0_i;
        end else if (r_state == ST_BUSY) begin
            r_cnt  <= r_cnt + 1'b1;
            r_prod <= w_rdiv ? {w_rem, r_prod[W_OPR-2:0], w_qbit} : {w_sum, r_prod[W_OPR-1:1]};
        end else if (r_state == ST_FIX) begin
            r_res  <= w_fix_res;
        end
    end
endmodule

// File: tb/tb_exec_iter_muldiv.sv
// tb_exec_iter_muldiv: randomized and directed checks against an arithmetic reference model
module tb_exec_iter_muldiv;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v_i = 1'b0, sign_i = 1'b0, flush_i = 1'b0, stall_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] opr0_i = '0, opr1_i = '0;
    logic [4:0]  wb_r_i = '0;
    logic        stall_o, v_o, divzero_o;
    logic [31:0] result_o;
    logic [4:0]  wb_r_o;

    int n_vec = 0;
    int n_err = 0;

    // reference state: edges left until the result appears, and the pending result
    int          m_busy = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_wb = '0;
    bit          m_dz = 1'b0;
    bit          m_stall;

    exec_iter_muldiv #(.W_OPR(32), .W_RD(5), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .v_i(v_i), .op_i(op_i), .sign_i(sign_i),
        .opr0_i(opr0_i), .opr1_i(opr1_i), .wb_r_i(wb_r_i), .flush_i(flush_i),
        .stall_i(stall_i), .stall_o(stall_o), .v_o(v_o), .result_o(result_o),
        .wb_r_o(wb_r_o), .divzero_o(divzero_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic sg,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = sg ? {{32{a[31]}}, a} : {32'b0, a};
        sb = sg ? {{32{b[31]}}, b} : {32'b0, b};
        p  = sa * sb;
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_valid = 0; m_dz = 0;
        end else begin
            m_stall = (m_busy != 0) || (m_valid && stall_i);
            if (flush_i) begin
                m_busy = 0; m_valid = 0; m_dz = 0;
            end else if (v_i && !m_stall) begin
                m_res = model(op_i, sign_i, opr0_i, opr1_i);
                m_wb  = wb_r_i;
                m_dz  = op_i[1] && opr1_i == 0;
                m_valid = m_dz;
                m_busy  = m_dz ? 0 : 33;
            end else if (m_busy != 0) begin
                m_busy--;
                if (m_busy == 0) m_valid = 1;
            end else if (m_valid && !stall_i) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("v_o", {31'b0, v_o}, {31'b0, m_valid});
        check("stall_o", {31'b0, stall_o}, {31'b0, (m_busy != 0) || (m_valid && stall_i)});
        if (m_valid) begin
            check("result_o", result_o, m_res);
            check("wb_r_o", {27'b0, wb_r_o}, {27'b0, m_wb});
            check("divzero_o", {31'b0, divzero_o}, {31'b0, m_dz});
        end
    end

    task automatic issue(input logic [1:0] op, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wb);
        int k;
        v_i = 1; op_i = op; sign_i = sg; opr0_i = a; opr1_i = b; wb_r_i = wb;
        k = 0;
        do begin @(negedge clk); k++; end while (stall_o && k < 200);
        if (k >= 200) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        v_i = 0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        do begin @(negedge clk); k++; end while (!v_o && k < 100);
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic sg,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] wb,
                          input logic [31:0] exp, input bit dz);
        int k;
        @(posedge clk); #1;
        issue(op, sg, a, b, wb);
        wait_valid(k);
        check({nm, "_latency"}, k, dz ? 32'd1 : 32'd34);
        check(nm, result_o, exp);
        check({nm, "_wb"}, {27'b0, wb_r_o}, {27'b0, wb});
        check({nm, "_dz"}, {31'b0, divzero_o}, {31'b0, dz});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        check("model_mul", model(2'd0, 0, 7, 6), 32'd42);
        check("model_mulh_u", model(2'd1, 0, '1, '1), 32'hFFFF_FFFE);
        check("model_div_s", model(2'd2, 1, -32'sd7, 32'd2), 32'hFFFF_FFFD);
        check("model_rem_s", model(2'd3, 1, -32'sd7, 32'd2), 32'hFFFF_FFFF);
        check("model_div_ovf", model(2'd2, 1, 32'h8000_0000, '1), 32'h8000_0000);
        @(negedge clk);
        check("rst_v", {31'b0, v_o}, 32'd0);
        check("rst_res", result_o, 32'd0);
        check("rst_wb", {27'b0, wb_r_o}, 32'd0);
        check("rst_dz", {31'b0, divzero_o}, 32'd0);
        @(posedge clk); #1 reset = 1;

        run_op("mul_7x6", 2'd0, 0, 7, 6, 5'd3, 32'd42, 0);
        run_op("mulh_u_max", 2'd1, 0, '1, '1, 5'd4, 32'hFFFF_FFFE, 0);
        run_op("mulh_s_m1", 2'd1, 1, '1, '1, 5'd5, 32'd0, 0);
        run_op("mul_s_neg", 2'd0, 1, -32'sd3, 32'd5, 5'd6, 32'hFFFF_FFF1, 0);
        run_op("div_s", 2'd2, 1, -32'sd7, 32'd2, 5'd7, 32'hFFFF_FFFD, 0);
        run_op("rem_s", 2'd3, 1, -32'sd7, 32'd2, 5'd8, 32'hFFFF_FFFF, 0);
        run_op("div_ovf", 2'd2, 1, 32'h8000_0000, '1, 5'd9, 32'h8000_0000, 0);
        run_op("rem_ovf", 2'd3, 1, 32'h8000_0000, '1, 5'd10, 32'd0, 0);
        run_op("div_u", 2'd2, 0, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'h7FFF_FFFC, 0);
        run_op("div_zero", 2'd2, 0, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
        run_op("rem_zero", 2'd3, 1, 32'd5, 32'd0, 5'd13, 32'd5, 1);

        // hold a result under downstream stall, then release with a new request waiting
        @(posedge clk); #1;
        stall_i = 1;
        issue(2'd0, 0, 3, 5, 5'd14);
        wait_valid(k);
        repeat (3) begin
            @(negedge clk);
            check("hold_v", {31'b0, v_o}, 32'd1);
            check("hold_res", result_o, 32'd15);
            check("hold_stall", {31'b0, stall_o}, 32'd1);
        end
        @(posedge clk); #1;
        stall_i = 0; v_i = 1; op_i = 2'd2; sign_i = 0; opr0_i = 100; opr1_i = 7; wb_r_i = 5'd15;
        @(negedge clk);
        check("b2b_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk); #1 v_i = 0;
        @(negedge clk);
        check("b2b_v_drop", {31'b0, v_o}, 32'd0);
        check("b2b_busy", {31'b0, stall_o}, 32'd1);
        wait_valid(k);
        check("b2b_res", result_o, 32'd14);

        // flush mid-iteration, plus a request dropped because it arrives with flush
        @(posedge clk); #1;
        issue(2'd0, 0, 9, 9, 5'd16);
        repeat (9) @(posedge clk);
        #1 flush_i = 1;
        @(posedge clk); #1;
        v_i = 1;
        @(posedge clk); #1;
        flush_i = 0; v_i = 0;
        @(negedge clk);
        check("flush_idle", {31'b0, stall_o}, 32'd0);
        k = 0;
        repeat (40) begin @(negedge clk); if (v_o) k++; end
        check("flush_no_v", k, 32'd0);

        // asynchronous reset in the middle of an operation
        @(posedge clk); #1;
        issue(2'd1, 1, 32'h1234_5678, 32'h8765_4321, 5'd17);
        repeat (5) @(posedge clk);
        #2 reset = 0;
        #1;
        check("arst_v", {31'b0, v_o}, 32'd0);
        check("arst_stall", {31'b0, stall_o}, 32'd0);
        check("arst_res", result_o, 32'd0);
        check("arst_wb", {27'b0, wb_r_o}, 32'd0);
        @(posedge clk); #1 reset = 1;
        run_op("after_rst", 2'd0, 0, 32'd1000, 32'd1000, 5'd18, 32'd1000000, 0);

        repeat (3000) begin
            @(posedge clk); #1;
            v_i = ($urandom % 3) != 0;
            op_i = 2'($urandom);
            sign_i = 1'($urandom);
            opr0_i = pick();
            opr1_i = pick();
            wb_r_i = 5'($urandom);
            stall_i = ($urandom % 4) == 0;
            flush_i = ($urandom % 64) == 0;
        end
        @(posedge clk); #1;
        v_i = 0; stall_i = 0; flush_i = 0;
        repeat (40) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
